// File: rtl/water_level_filter.sv
// Water-level probe conditioner: 2-flop sync, per-probe debounce, plausibility FSM.
// Build option: define WATER_FAULT_STICKY_EN to latch sensor_fault until reset.
module water_level_filter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FAULT_CYCLES    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_high,
  input  logic raw_mid,
  input  logic raw_low,
  output logic high,
  output logic mid,
  output logic low,
  output logic level_changed,
  output logic sensor_fault
);

  // state     | meaning
  // S_TRACK   | debounced pattern plausible, outputs follow it
  // S_SUSPECT | implausible pattern seen, counting persistence
  // S_FAULT   | implausible pattern persisted, outputs frozen
  typedef enum logic [1:0] {
    S_TRACK   = 2'd0,
    S_SUSPECT = 2'd1,
    S_FAULT   = 2'd2
  } state_e;

  localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int FCW = (FAULT_CYCLES > 1) ? $clog2(FAULT_CYCLES) : 1;
  localparam logic [DCW-1:0] DMAX = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FCW-1:0] FMAX = FCW'(FAULT_CYCLES - 1);

  logic [2:0]     s1_q, s1_d;
  logic [2:0]     s2_q, s2_d;
  logic [2:0]     deb_q, deb_d;
  logic [DCW-1:0] cnt_q [3];
  logic [DCW-1:0] cnt_d [3];
  state_e         state_q, state_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic [2:0]     lvl_q, lvl_d;
  logic           lc_q, lc_d;
  logic           fault_q, fault_d;
  logic           pat_ok;

  // Bit order throughout is {high, mid, low}.
  always_comb begin
    s1_d  = {raw_high, raw_mid, raw_low};
    s2_d  = s1_q;
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DMAX) begin
          deb_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DCW'(1);
        end
      end
    end
  end

  // A wet probe may never sit above a dry one.
  always_comb begin
    pat_ok = (deb_q == 3'b000) || (deb_q == 3'b001) ||
             (deb_q == 3'b011) || (deb_q == 3'b111);
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    lvl_d   = lvl_q;
    fault_d = fault_q;
    case (state_q)
      S_TRACK: begin
        if (pat_ok) begin
          lvl_d = deb_q;
        end else if (FAULT_CYCLES == 1) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          state_d = S_SUSPECT;
          fcnt_d  = FCW'(1);
        end
      end
      S_SUSPECT: begin
        if (pat_ok) begin
          state_d = S_TRACK;
          lvl_d   = deb_q;
          fcnt_d  = '0;
        end else if (fcnt_q == FMAX) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + FCW'(1);
        end
      end
      S_FAULT: begin
`ifdef WATER_FAULT_STICKY_EN
        state_d = S_FAULT;
`else
        if (pat_ok) begin
          state_d = S_TRACK;
          fault_d = 1'b0;
          lvl_d   = deb_q;
        end
`endif
      end
      default: begin
        state_d = S_TRACK;
        fcnt_d  = '0;
      end
    endcase
    lc_d = (lvl_d != lvl_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      state_q <= S_TRACK;
      fcnt_q  <= '0;
      lvl_q   <= '0;
      lc_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      deb_q   <= deb_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      lvl_q   <= lvl_d;
      lc_q    <= lc_d;
      fault_q <= fault_d;
    end
  end

  assign high          = lvl_q[2];
  assign mid           = lvl_q[1];
  assign low           = lvl_q[0];
  assign level_changed = lc_q;
  assign sensor_fault  = fault_q;

endmodule

// File: tb/tb_water_level_filter.sv
// Scoreboard bench for water_level_filter: per-edge expectations from a behavioural model.
module tb_water_level_filter;
  localparam int D  = 4;
  localparam int FC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw_high = 1'b0, raw_mid = 1'b0, raw_low = 1'b0;
  logic high, mid, low, level_changed, sensor_fault;

  water_level_filter #(.DEBOUNCE_CYCLES(D), .FAULT_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .raw_high(raw_high), .raw_mid(raw_mid), .raw_low(raw_low),
    .high(high), .mid(mid), .low(low),
    .level_changed(level_changed), .sensor_fault(sensor_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [4:0] sb [$];   // {hml, level_changed, sensor_fault}

  // Behavioural model state: pipeline of raw samples, per-probe run of disagreement
  logic [2:0] m_s1 = 0, m_s2 = 0, m_deb = 0, m_out = 0;
  int         m_run [3];
  int         m_inv = 0;
  logic       m_fault = 0, m_lc = 0;

  function automatic bit plausible(input logic [2:0] p);
    return p == 3'b000 || p == 3'b001 || p == 3'b011 || p == 3'b111;
  endfunction

  task automatic model_edge();
    logic [2:0] raw_now, new_deb, new_out;
    bit sticky;
`ifdef WATER_FAULT_STICKY_EN
    sticky = 1;
`else
    sticky = 0;
`endif
    raw_now = {raw_high, raw_mid, raw_low};
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_out = 0; m_inv = 0; m_fault = 0; m_lc = 0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      return;
    end
    // A probe is accepted once the synced value has disagreed for D straight cycles.
    new_deb = m_deb;
    for (int i = 0; i < 3; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] >= D) begin new_deb[i] = m_s2[i]; m_run[i] = 0; end
      end else m_run[i] = 0;
    end
    new_out = m_out;
    if (plausible(m_deb)) begin
      m_inv = 0;
      if (!(sticky && m_fault)) begin m_fault = 0; new_out = m_deb; end
    end else begin
      m_inv++;
      if (m_inv >= FC) m_fault = 1;
    end
    m_lc  = (new_out != m_out);
    m_out = new_out;
    m_deb = new_deb;
    m_s2  = m_s1;
    m_s1  = raw_now;
  endtask

  // One clock: model the edge using values applied before it, then apply the next inputs.
  task automatic step(input logic r, input logic [2:0] rv);
    @(posedge clk);
    model_edge();
    sb.push_back({m_out, m_lc, m_fault});
    cyc++;
    #1;
    rst = r;
    {raw_high, raw_mid, raw_low} = rv;
  endtask

  task automatic hold(input logic [2:0] rv, input int n);
    for (int i = 0; i < n; i++) step(1'b0, rv);
  endtask

  initial begin : monitor
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({high, mid, low} !== e[4:2] || level_changed !== e[1] || sensor_fault !== e[0]) begin
          errors++;
          $display("FAIL cyc%0d outputs got hml=%b lc=%b flt=%b want hml=%b lc=%b flt=%b",
                   cyc, {high, mid, low}, level_changed, sensor_fault, e[4:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin : stim
    logic [2:0] pat;
    int len;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    step(1'b1, 3'b000);
    step(1'b1, 3'b000);
    step(1'b0, 3'b000);
    hold(3'b000, 20);
    hold(3'b001, 12);
    hold(3'b011, 3);           // mid glitch shorter than debounce
    hold(3'b001, 12);
    hold(3'b011, 12);
    hold(3'b101, 14);          // implausible: fault after FC cycles
    hold(3'b111, 12);
    hold(3'b000, 14);
    hold(3'b100, 4);           // brief implausible patterns
    hold(3'b000, 14);
    hold(3'b100, 5);
    hold(3'b000, 14);
    hold(3'b100, 6);
    hold(3'b000, 14);
    hold(3'b011, 12);
    hold(3'b111, 3);           // reset lands mid-debounce
    step(1'b1, 3'b111);
    hold(3'b111, 14);
    step(1'b1, 3'b000);
    step(1'b0, 3'b000);
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(99) < 75) begin
        case ($urandom_range(3))
          0: pat = 3'b000;
          1: pat = 3'b001;
          2: pat = 3'b011;
          default: pat = 3'b111;
        endcase
      end else begin
        pat = 3'($urandom_range(7));
      end
      len = $urandom_range(1, 12);
      if ($urandom_range(99) < 3) step(1'b1, pat);
      hold(pat, len);
    end
    hold(3'b000, 3);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain leftover=%0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/water_level_filter.md
Name: water_level_filter

Overview:
- Conditions the three raw water-level probe inputs (high/mid/low) before they reach the water-level encoder stage.
- Per probe, in order: synchronise, then debounce.
- Then checks the probe combination for physical plausibility and holds the last valid level while the probe set is faulty.
- Its high/mid/low outputs connect directly to the encoder's high/mid/low inputs.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised probe must hold a new value before it is accepted (>=1)
FAULT_CYCLES, 3, consecutive cycles an implausible debounced pattern must persist before the fault is raised (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
raw_high  input  1  asynchronous high-level probe
raw_mid  input  1  asynchronous mid-level probe
raw_low  input  1  asynchronous low-level probe
high  output  1  filtered high probe, registered
mid  output  1  filtered mid probe, registered
low  output  1  filtered low probe, registered
level_changed  output  1  one-cycle pulse when {high,mid,low} changes
sensor_fault  output  1  implausible probe combination persisted

Behaviour:
- Reset is synchronous and active-high: rst sampled high at a rising clk edge resets the block; no asynchronous reset path.
- Reset values: all outputs 0, i.e. {high,mid,low}=000 (critical); sync flops 0; debounced bits 0; counters 0; FSM=TRACK. Reset mid-operation discards in-progress debounce and fault counts immediately.
- Synchroniser: two flops per probe.
- Debounce, per probe:
  - Counter increments while the synced value differs from the debounced value.
  - Counter clears to 0 whenever they are equal, so glitches shorter than DEBOUNCE_CYCLES are rejected.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, the debounced bit takes the synced value at the next edge and the counter clears.
- Latency: a raw change first sampled at edge N reaches high/mid/low at edge N+DEBOUNCE_CYCLES+2 (2 sync, DEBOUNCE_CYCLES debounce, 1 output register).
- Plausibility, on debounced {H,M,L}: valid = 000, 001, 011, 111. All other patterns are invalid (a probe asserted above a dry probe).
- FSM, updated every cycle:
  - TRACK:
    - valid pattern -> outputs load the pattern next edge.
    - invalid pattern -> SUSPECT; outputs hold; fault counter=1.
  - SUSPECT:
    - valid pattern -> TRACK; outputs load the pattern next edge; counter clears.
    - invalid pattern, counter < FAULT_CYCLES-1 -> counter increments.
    - invalid pattern, counter = FAULT_CYCLES-1 -> FAULT.
  - FAULT:
    - sensor_fault=1 (registered, asserted the edge FAULT is entered); outputs hold the last valid pattern.
    - valid pattern -> TRACK; sensor_fault drops and outputs load the pattern on the same edge.
- FAULT_CYCLES=1: an invalid pattern goes TRACK -> FAULT directly.
- level_changed:
  - Registered; high for exactly one cycle following any edge where {high,mid,low} takes a different value.
  - Never asserted by reset.
  - Not asserted when outputs reload an identical value.
- Simultaneous debounce completion on several probes in one edge is evaluated as one new pattern, giving at most one level_changed pulse.
- Outputs can only ever present a valid pattern.

Optional Feature:
- Macro: WATER_FAULT_STICKY_EN.
- Defined: FAULT is latched. A valid pattern does not exit FAULT; only rst clears sensor_fault. Outputs remain frozen at the last valid pattern until reset.
- Undefined: FAULT exits to TRACK on the first valid debounced pattern, as described in Behaviour.

Test Plan:
- Reset then raw {H,M,L}=000 held 20 cycles -> outputs 000, sensor_fault=0, level_changed never pulses.
- raw 000->001 at edge N (DEBOUNCE_CYCLES=4) -> low=1 at edge N+6; level_changed=1 for one cycle only; nothing earlier.
- raw_mid glitch high for 3 cycles with outputs at 001 -> outputs stay 001; no level_changed.
- Outputs at 011; raw set to 101 and held -> outputs hold 011; sensor_fault=1 exactly FAULT_CYCLES=3 cycles after the debounced pattern becomes 101. Raw then 111 -> sensor_fault clears and outputs 111 at the same edge (macro undefined); with WATER_FAULT_STICKY_EN, sensor_fault stays 1 and outputs stay 011 until rst.
- Invalid 100 for 2 cycles then valid 000 (FAULT_CYCLES=3) -> no sensor_fault; outputs update to 000 with one level_changed pulse.
- rst asserted mid-debounce of 011->111 -> next edge outputs 000, counters cleared, sensor_fault=0, level_changed=0.
